// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART RX two-byte command framer.
package uart_rx_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ADDR = 2'd1,
      ST_ISSUE     = 2'd2
   } state_e;

   localparam int CMD_W  = 3;
   localparam int ADDR_W = 5;

   localparam logic [3:0] NBITS_8       = 4'b1000;
   // Header bits that must be zero in the command byte and the address byte.
   localparam logic [7:0] CMD_HDR_MASK  = 8'hF8;
   localparam logic [7:0] ADDR_HDR_MASK = 8'hE0;

   function automatic logic hdr_clear(input logic [7:0] b, input logic [7:0] mask);
      return (b & mask) == 8'h00;
   endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Receiver-side and sensor-side signals of the framer, bundled with modports.
interface uart_rx_frame_ctrl_if;
   import uart_rx_frame_ctrl_pkg::*;

   logic              RxDone;
   logic [7:0]        RxData;
   logic              RxEn;
   logic [3:0]        NBits;
   logic              CmdValid;
   logic [CMD_W-1:0]  CmdCode;
   logic [ADDR_W-1:0] CmdAddr;
   logic              CmdReady;
   logic              FrameErr;
   logic              Busy;

   modport slave (
      input  RxDone, RxData, CmdReady,
      output RxEn, NBits, CmdValid, CmdCode, CmdAddr, FrameErr, Busy
   );

   modport master (
      output RxDone, RxData, CmdReady,
      input  RxEn, NBits, CmdValid, CmdCode, CmdAddr, FrameErr, Busy
   );

endinterface

// File: rtl/uart_rx_frame_ctrl_frame_timer.sv
// Saturating inter-byte timeout counter; expired_o flags LIMIT-1 reached.
module frame_timer #(
   parameter int unsigned LIMIT = 50000
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == LAST);

   // Holds at LAST rather than wrapping back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !expired_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Assembles a command byte and an address byte from a UART receiver into a
// valid/ready command, rejecting malformed or timed-out frames.
module uart_rx_frame_ctrl
   import uart_rx_frame_ctrl_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned TIMEOUT_CLKS = 50000
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   uart_rx_frame_ctrl_if.slave  bus
);

   if (CLKS_PER_BIT == 0 || TIMEOUT_CLKS < 2) begin : g_bad_cfg
      $error("uart_rx_frame_ctrl: CLKS_PER_BIT must be nonzero and TIMEOUT_CLKS at least 2");
   end

   state_e            state_q, state_d;
   logic              rx_done_q;
   logic              accept, reject, timeout;
   logic              rx_en_q, rx_en_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [CMD_W-1:0]  code_q, code_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   // History resets high so a level already high at reset release is not an edge.
   assign accept = bus.RxDone && !rx_done_q && (state_q != ST_ISSUE);

   frame_timer #(.LIMIT(TIMEOUT_CLKS)) u_timer (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .clr_i     (state_q != ST_WAIT_ADDR),
      .en_i      (state_q == ST_WAIT_ADDR),
      .expired_o (timeout)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         rx_done_q   <= 1'b1;
         rx_en_q     <= 1'b0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         code_q      <= '0;
         addr_q      <= '0;
      end else begin
         state_q     <= state_d;
         rx_done_q   <= bus.RxDone;
         rx_en_q     <= rx_en_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
         code_q      <= code_d;
         addr_q      <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      reject  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (hdr_clear(bus.RxData, CMD_HDR_MASK)) state_d = ST_WAIT_ADDR;
               else                                      reject  = 1'b1;
            end
         end
         ST_WAIT_ADDR: begin
            // A byte arriving in the expiry cycle takes priority over the timeout.
            if (accept) begin
               if (hdr_clear(bus.RxData, ADDR_HDR_MASK)) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
                  reject  = 1'b1;
               end
            end else if (timeout) begin
               state_d = ST_IDLE;
               reject  = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (cmd_valid_q && bus.CmdReady) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_en_d     = (state_d != ST_ISSUE);
      cmd_valid_d = (state_d == ST_ISSUE);
      frame_err_d = reject;
      code_d      = code_q;
      addr_d      = addr_q;
      if (state_q == ST_IDLE && state_d == ST_WAIT_ADDR)
         code_d = bus.RxData[CMD_W-1:0];
      if (state_q == ST_WAIT_ADDR && state_d == ST_ISSUE)
         addr_d = bus.RxData[ADDR_W-1:0];
   end

   assign bus.RxEn     = rx_en_q;
   assign bus.NBits    = NBITS_8;
   assign bus.CmdValid = cmd_valid_q;
   assign bus.CmdCode  = code_q;
   assign bus.CmdAddr  = addr_q;
   assign bus.FrameErr = frame_err_q;
   assign bus.Busy     = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, serial bit period in Clk cycles, informational for timeout sizing.
REQ-002 Parameter TIMEOUT_CLKS, default 50000, maximum Clk cycles allowed between frame byte 0 and frame byte 1.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 RxDone  input  1  receiver byte-complete flag; level, may stay high for many cycles.
REQ-006 RxData  input  8  received byte, valid when RxDone is high.
REQ-007 RxEn  output  1  receiver enable.
REQ-008 NBits  output  4  receiver word length; constant 4'b1000.
REQ-009 CmdValid  output  1  command available to the sensor side.
REQ-010 CmdCode  output  3  decoded command, from byte 0 bits [2:0].
REQ-011 CmdAddr  output  5  target sensor address, from byte 1 bits [4:0].
REQ-012 CmdReady  input  1  sensor side accepts the command.
REQ-013 FrameErr  output  1  one-cycle pulse on a rejected frame.
REQ-014 Busy  output  1  high in any state other than IDLE.

Function
REQ-015 A byte shall be accepted only on a rising edge of RxDone, detected against a registered copy of RxDone; one accepted byte per edge.
REQ-016 The FSM shall have the states IDLE, WAIT_ADDR, ISSUE.
REQ-017 IDLE: on an accepted byte with bits [7:3]==0, latch bits [2:0] into CmdCode, clear the timer, and go to WAIT_ADDR; any other accepted byte pulses FrameErr and stays in IDLE.
REQ-018 WAIT_ADDR: on an accepted byte with bits [7:5]==0, latch bits [4:0] into CmdAddr and go to ISSUE; any other accepted byte pulses FrameErr and returns to IDLE.
REQ-019 WAIT_ADDR: the timer shall increment every cycle; when it reaches TIMEOUT_CLKS-1 with no accepted byte, pulse FrameErr and return to IDLE.
REQ-020 If an accepted byte and the timeout occur in the same cycle, the byte shall win and the timeout is ignored.
REQ-021 ISSUE: CmdValid shall be high, with CmdCode and CmdAddr held stable.
REQ-022 ISSUE: a cycle with CmdValid and CmdReady both high completes the transfer; the next state is IDLE and CmdValid is low in the following cycle.
REQ-023 CmdValid shall assert the cycle after the byte-1 acceptance edge (latency 1 cycle).
REQ-024 RxEn shall be high in IDLE and WAIT_ADDR and low in ISSUE; RxDone edges arriving in ISSUE are discarded.
REQ-025 The timer width shall be $clog2(TIMEOUT_CLKS); the timer shall saturate and never wrap.
REQ-026 FrameErr shall be registered and high for exactly one cycle per rejected frame.

Reset
REQ-027 Reset values: state IDLE, RxEn 0, CmdValid 0, CmdCode 0, CmdAddr 0, FrameErr 0, Busy 0, timer 0, RxDone history 1.
REQ-028 Resetting the RxDone history to 1 prevents a stale high RxDone from counting as an edge after reset.
REQ-029 RxEn shall rise to 1 in the first cycle after reset deassertion.
REQ-030 NBits shall be 4'b1000 in all states, including during reset.
REQ-031 Reset asserted in any state shall abort the frame immediately with no FrameErr pulse.

Structure
REQ-032 A shared package shall hold the state enum, CMD_W=3, ADDR_W=5, the NBITS_8 constant, and the byte-field masks.
REQ-033 One sub-module, frame_timer, shall provide the saturating timeout counter (clear, enable, and expired output).
REQ-034 All other logic shall be flat within uart_rx_frame_ctrl.

Verification
REQ-035 Valid frame: byte 0x03, then byte 0x11 within the timeout -> CmdValid one cycle after the second edge, CmdCode=3, CmdAddr=0x11; with CmdReady held high, back in IDLE one cycle later.
REQ-036 Backpressure: CmdReady low for 20 cycles -> CmdValid and fields held stable and RxEn=0; an extra RxDone edge in that window is ignored.
REQ-037 Bad bytes: byte 0 = 0x48 -> FrameErr one-cycle pulse, stays IDLE; byte 0x01 then 0xE0 -> FrameErr, IDLE, no CmdValid.
REQ-038 Timeout (TIMEOUT_CLKS=100): byte 0x02 with no second byte -> FrameErr exactly 100 cycles later; a second byte landing on cycle 99 -> accepted, no FrameErr.
REQ-039 RxDone held high for 500 cycles -> exactly one byte accepted.
REQ-040 Reset mid-frame in WAIT_ADDR with RxDone high -> IDLE, no FrameErr, no phantom byte acceptance after release.
